// File: rtl/ps2_rx_fifo_if.sv
// Host-side bundle of the PS/2 receiver: FIFO read port, error clear and status flags.
// Handshake: an entry is offered while ready=1; rd_en=1 sampled on a rising clk with ready=1 pops it.
interface ps2_rx_fifo_if #(
  parameter int FIFO_DEPTH = 8
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          rd_en;
  logic          err_clr;
  logic [9:0]    data;
  logic          ready;
  logic          overflow;
  logic          parity_err;
  logic          frame_err;
  logic [CW-1:0] count;

  modport master (
    output rd_en, err_clr,
    input  data, ready, overflow, parity_err, frame_err, count
  );

  modport slave (
    input  rd_en, err_clr,
    output data, ready, overflow, parity_err, frame_err, count
  );
endinterface

// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: synchroniser, 11-bit frame deframer with parity/stop/timeout checks,
// optional E0/F0 prefix folding, and a show-ahead FIFO of decoded {ext, brk, code} entries.
module ps2_rx_fifo #(
  parameter int FIFO_DEPTH     = 8,
  parameter int SYNC_STAGES    = 3,
  parameter int TIMEOUT_CYCLES = 20000,
  parameter int DECODE_PREFIX  = 1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              ps2_clk,
  input  logic              ps2_data,
  ps2_rx_fifo_if.slave      bus,
  output logic [2:0]        fsm_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RECV    = 3'd1,
    S_PARITY  = 3'd2,
    S_STOP    = 3'd3,
    S_DELIVER = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] clk_sync, data_sync;
  logic                   clk_prev;
  logic                   fall;
  logic                   bit_in;

  logic [7:0]    shreg_q;
  logic [2:0]    bitcnt_q;
  logic          par_q;
  logic [TW-1:0] timer_q;
  logic          timer_hit;
  logic          in_frame;
  logic          parity_ok;

  logic          set_perr, set_ferr, deliver;
  logic          ext_pend, brk_pend;
  logic          is_e0, is_f0, is_prefix;
  logic          push_req;
  logic [9:0]    push_data;

  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_q;
  logic          full, empty, pop, push_acc, drop;
  logic          overflow_q, parity_err_q, frame_err_q;

  // Bus idles high, so the synchronisers reset to 1 to avoid a phantom falling edge.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev  <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign fall      = clk_prev & ~clk_sync[SYNC_STAGES-1];
  assign bit_in    = data_sync[SYNC_STAGES-1];
  assign timer_hit = (timer_q == TW'(TIMEOUT_CYCLES));
  assign in_frame  = (state_q == S_RECV) || (state_q == S_PARITY) || (state_q == S_STOP);
  assign parity_ok = ^{shreg_q, par_q};

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // A ps2_clk edge takes priority over a timeout landing in the same cycle.
  always_comb begin
    state_d  = state_q;
    set_perr = 1'b0;
    set_ferr = 1'b0;
    deliver  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fall && !bit_in) state_d = S_RECV;
      end
      S_RECV: begin
        if (fall) begin
          if (bitcnt_q == 3'd7) state_d = S_PARITY;
        end else if (timer_hit) begin
          set_ferr = 1'b1;
          state_d  = S_IDLE;
        end
      end
      S_PARITY: begin
        if (fall) begin
          state_d = S_STOP;
        end else if (timer_hit) begin
          set_ferr = 1'b1;
          state_d  = S_IDLE;
        end
      end
      S_STOP: begin
        if (fall) begin
          if (bit_in && parity_ok) begin
            state_d = S_DELIVER;
          end else if (bit_in) begin
            set_perr = 1'b1;
            state_d  = S_IDLE;
          end else begin
            set_ferr = 1'b1;
            state_d  = S_IDLE;
          end
        end else if (timer_hit) begin
          set_ferr = 1'b1;
          state_d  = S_IDLE;
        end
      end
      S_DELIVER: begin
        deliver = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      shreg_q  <= '0;
      bitcnt_q <= '0;
      par_q    <= 1'b0;
      timer_q  <= '0;
    end else begin
      if (!in_frame || fall)  timer_q <= '0;
      else if (!timer_hit)    timer_q <= timer_q + TW'(1);

      case (state_q)
        S_IDLE: begin
          if (fall && !bit_in) begin
            bitcnt_q <= '0;
            shreg_q  <= '0;
          end
        end
        S_RECV: begin
          if (fall) begin
            shreg_q  <= {bit_in, shreg_q[7:1]};
            bitcnt_q <= bitcnt_q + 3'd1;
          end else if (timer_hit) begin
            shreg_q <= '0;
          end
        end
        S_PARITY: begin
          if (fall) par_q <= bit_in;
          else if (timer_hit) shreg_q <= '0;
        end
        S_STOP: begin
          if (!fall && timer_hit) shreg_q <= '0;
        end
        default: ;
      endcase
    end
  end

  assign is_e0     = (shreg_q == 8'hE0);
  assign is_f0     = (shreg_q == 8'hF0);
  assign is_prefix = (DECODE_PREFIX != 0) && (is_e0 || is_f0);

  always_comb begin
    push_req  = 1'b0;
    push_data = '0;
    if (deliver && !is_prefix) begin
      push_req = 1'b1;
      if (DECODE_PREFIX != 0) push_data = {ext_pend, brk_pend, shreg_q};
      else                    push_data = {2'b00, shreg_q};
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      ext_pend <= 1'b0;
      brk_pend <= 1'b0;
    end else if (deliver && (DECODE_PREFIX != 0)) begin
      if (is_e0) begin
        ext_pend <= 1'b1;
      end else if (is_f0) begin
        brk_pend <= 1'b1;
      end else begin
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
      end
    end
  end

  assign full     = (count_q == CW'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign pop      = bus.rd_en && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push_acc = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  always_ff @(posedge clk) begin
    if (push_acc) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + AW'(1);
      if (pop)      rd_ptr <= rd_ptr + AW'(1);
      case ({push_acc, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (drop)     overflow_q <= 1'b1;
      else if (pop) overflow_q <= 1'b0;
    end
  end

  // A new error in the same cycle as err_clr wins.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      if (set_perr)         parity_err_q <= 1'b1;
      else if (bus.err_clr) parity_err_q <= 1'b0;
      if (set_ferr)         frame_err_q  <= 1'b1;
      else if (bus.err_clr) frame_err_q  <= 1'b0;
    end
  end

  // Gating on empty keeps data at zero straight out of reset without clearing the array.
  assign bus.data       = empty ? 10'h000 : mem[rd_ptr];
  assign bus.ready      = !empty;
  assign bus.count      = count_q;
  assign bus.overflow   = overflow_q;
  assign bus.parity_err = parity_err_q;
  assign bus.frame_err  = frame_err_q;
  assign fsm_state      = state_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: a prefix-folding instance and a raw instance share the PS/2 lines.
module tb_ps2_rx_fifo;

  localparam int DEPTH = 8;
  localparam int SYNC  = 3;
  localparam int TMO   = 2000;
  localparam int H     = 10;

  logic       clk = 1'b0;
  logic       clr;
  logic       ps2_clk;
  logic       ps2_data;
  logic [2:0] st, st_raw;

  int n_checks = 0;
  int n_fail   = 0;

  logic [9:0] exp_q[$];

  ps2_rx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus ();
  ps2_rx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus_raw ();

  ps2_rx_fifo #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TMO), .DECODE_PREFIX(1)) dut (
    .clk(clk), .clr(clr), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .bus(bus), .fsm_state(st)
  );

  ps2_rx_fifo #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TMO), .DECODE_PREFIX(0)) dut_raw (
    .clk(clk), .clr(clr), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .bus(bus_raw), .fsm_state(st_raw)
  );

  // clock/reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish within 2ms");
    $fatal(1, "watchdog expired");
  end

  // drivers
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    clr = 1'b1;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    bus.rd_en = 1'b0;
    bus.err_clr = 1'b0;
    bus_raw.rd_en = 1'b0;
    bus_raw.err_clr = 1'b0;
    tick(3);
    clr = 1'b0;
    tick(2);
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    tick(H);
    ps2_clk = 1'b0;
    tick(H);
    ps2_clk = 1'b1;
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) send_bit(bits[i]);
  endtask

  function automatic logic [10:0] frame(input logic [7:0] code, input logic par_flip, input logic stop);
    return {stop, (~^code) ^ par_flip, code, 1'b0};
  endfunction

  task automatic send_frame(input logic [7:0] code);
    send_bits(frame(code, 1'b0, 1'b1), 11);
    tick(4);
  endtask

  task automatic pop_main();
    bus.rd_en = 1'b1;
    tick(1);
    bus.rd_en = 1'b0;
  endtask

  task automatic pop_raw();
    bus_raw.rd_en = 1'b1;
    tick(1);
    bus_raw.rd_en = 1'b0;
  endtask

  // tests
  task automatic test_reset();
    do_reset();
    n_checks++; if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", bus.ready); end
    n_checks++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", bus.count); end
    n_checks++; if (bus.data !== 10'h000) begin n_fail++; $display("FAIL reset_data: got %h expected 000", bus.data); end
    n_checks++; if ({bus.overflow, bus.parity_err, bus.frame_err} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {bus.overflow, bus.parity_err, bus.frame_err}); end
    n_checks++; if (st !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", st); end
  endtask

  task automatic test_valid_frame();
    int lat;
    logic found;
    do_reset();
    send_bits(frame(8'h1C, 1'b0, 1'b1), 10);
    ps2_data = 1'b1;
    tick(H);
    ps2_clk = 1'b0;
    lat = 0;
    found = 1'b0;
    for (int i = 1; i <= 30 && !found; i++) begin
      tick(1);
      if (bus.ready) begin
        found = 1'b1;
        lat = i;
      end
    end
    ps2_clk = 1'b1;
    tick(H);
    n_checks++; if (!found || lat != SYNC + 2) begin n_fail++; $display("FAIL valid_latency: got %0d expected %0d", lat, SYNC + 2); end
    n_checks++; if (bus.data !== 10'h01C) begin n_fail++; $display("FAIL valid_data: got %h expected 01C", bus.data); end
    n_checks++; if (bus.count !== 4'd1) begin n_fail++; $display("FAIL valid_count: got %0d expected 1", bus.count); end
    pop_main();
    n_checks++; if (bus.ready !== 1'b0 || bus.count !== 4'd0) begin n_fail++; $display("FAIL valid_pop: got ready=%b count=%0d expected ready=0 count=0", bus.ready, bus.count); end
  endtask

  task automatic test_prefix();
    do_reset();
    send_frame(8'hE0);
    n_checks++; if (bus.count !== 4'd0 || bus_raw.count !== 4'd1) begin n_fail++; $display("FAIL prefix_e0: got count=%0d raw=%0d expected 0 and 1", bus.count, bus_raw.count); end
    send_frame(8'hF0);
    send_frame(8'h75);
    n_checks++; if (bus.count !== 4'd1) begin n_fail++; $display("FAIL prefix_count: got %0d expected 1", bus.count); end
    n_checks++; if (bus.data !== 10'h375) begin n_fail++; $display("FAIL prefix_data: got %h expected 375", bus.data); end
    n_checks++; if (bus_raw.count !== 4'd3) begin n_fail++; $display("FAIL raw_count: got %0d expected 3", bus_raw.count); end
    exp_q.push_back(10'h0E0);
    exp_q.push_back(10'h0F0);
    exp_q.push_back(10'h075);
    while (exp_q.size() > 0) begin
      logic [9:0] e;
      e = exp_q.pop_front();
      n_checks++; if (bus_raw.data !== e) begin n_fail++; $display("FAIL raw_data: got %h expected %h", bus_raw.data, e); end
      pop_raw();
    end
    pop_main();
    send_frame(8'h1C);
    n_checks++; if (bus.data !== 10'h01C) begin n_fail++; $display("FAIL prefix_cleared: got %h expected 01C", bus.data); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int c = 8'h16; c <= 8'h1E; c++) send_frame(8'(c));
    n_checks++; if (bus.count !== 4'd8) begin n_fail++; $display("FAIL ovf_count: got %0d expected 8", bus.count); end
    n_checks++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b expected 1", bus.overflow); end
    n_checks++; if (bus.data !== 10'h016) begin n_fail++; $display("FAIL ovf_head: got %h expected 016", bus.data); end
    pop_main();
    n_checks++; if (bus.overflow !== 1'b0 || bus.data !== 10'h017 || bus.count !== 4'd7) begin n_fail++; $display("FAIL ovf_pop: got ovf=%b head=%h count=%0d expected 0 017 7", bus.overflow, bus.data, bus.count); end
    send_frame(8'h1F);
    n_checks++; if (bus.count !== 4'd8 || bus.overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_refill: got count=%0d ovf=%b expected 8 0", bus.count, bus.overflow); end
    // Final edge of 0x20 with rd_en timed to the DELIVER write cycle.
    send_bits(frame(8'h20, 1'b0, 1'b1), 10);
    ps2_data = 1'b1;
    tick(H);
    ps2_clk = 1'b0;
    for (int i = 1; i <= SYNC + 2; i++) begin
      tick(1);
      if (i == SYNC + 1) bus.rd_en = 1'b1;
      if (i == SYNC + 2) bus.rd_en = 1'b0;
    end
    ps2_clk = 1'b1;
    tick(H);
    n_checks++; if (bus.count !== 4'd8 || bus.overflow !== 1'b0) begin n_fail++; $display("FAIL full_pushpop: got count=%0d ovf=%b expected 8 0", bus.count, bus.overflow); end
    n_checks++; if (bus.data !== 10'h018) begin n_fail++; $display("FAIL full_head: got %h expected 018", bus.data); end
    exp_q.push_back(10'h018); exp_q.push_back(10'h019); exp_q.push_back(10'h01A); exp_q.push_back(10'h01B);
    exp_q.push_back(10'h01C); exp_q.push_back(10'h01D); exp_q.push_back(10'h01F); exp_q.push_back(10'h020);
    while (exp_q.size() > 0) begin
      logic [9:0] e;
      e = exp_q.pop_front();
      n_checks++; if (bus.data !== e) begin n_fail++; $display("FAIL drain_data: got %h expected %h", bus.data, e); end
      pop_main();
    end
    n_checks++; if (bus.count !== 4'd0 || bus.ready !== 1'b0) begin n_fail++; $display("FAIL drain_empty: got count=%0d ready=%b expected 0 0", bus.count, bus.ready); end
  endtask

  task automatic test_parity();
    do_reset();
    send_bits(frame(8'h1C, 1'b1, 1'b1), 11);
    tick(4);
    n_checks++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL parity_nopush: got %0d expected 0", bus.count); end
    n_checks++; if (bus.parity_err !== 1'b1 || bus.frame_err !== 1'b0) begin n_fail++; $display("FAIL parity_flag: got perr=%b ferr=%b expected 1 0", bus.parity_err, bus.frame_err); end
    bus.err_clr = 1'b1;
    tick(1);
    bus.err_clr = 1'b0;
    n_checks++; if (bus.parity_err !== 1'b0) begin n_fail++; $display("FAIL parity_clr: got %b expected 0", bus.parity_err); end
    send_frame(8'h1C);
    n_checks++; if (bus.data !== 10'h01C || bus.count !== 4'd1) begin n_fail++; $display("FAIL parity_recover: got %h count=%0d expected 01C 1", bus.data, bus.count); end
  endtask

  task automatic test_timeout();
    do_reset();
    send_bits(frame(8'h29, 1'b0, 1'b1), 5);
    tick(TMO / 2);
    n_checks++; if (bus.frame_err !== 1'b0 || st !== 3'd1) begin n_fail++; $display("FAIL tmo_early: got ferr=%b state=%0d expected 0 1", bus.frame_err, st); end
    tick(TMO);
    n_checks++; if (bus.frame_err !== 1'b1 || st !== 3'd0) begin n_fail++; $display("FAIL tmo_flag: got ferr=%b state=%0d expected 1 0", bus.frame_err, st); end
    send_frame(8'h29);
    n_checks++; if (bus.data !== 10'h029 || bus.count !== 4'd1) begin n_fail++; $display("FAIL tmo_recover: got %h count=%0d expected 029 1", bus.data, bus.count); end
    bus.err_clr = 1'b1;
    tick(1);
    bus.err_clr = 1'b0;
    n_checks++; if (bus.frame_err !== 1'b0) begin n_fail++; $display("FAIL tmo_clr: got %b expected 0", bus.frame_err); end
    send_bits(frame(8'h33, 1'b0, 1'b0), 11);
    tick(4);
    n_checks++; if (bus.frame_err !== 1'b1 || bus.parity_err !== 1'b0 || bus.count !== 4'd1) begin n_fail++; $display("FAIL stop_bad: got ferr=%b perr=%b count=%0d expected 1 0 1", bus.frame_err, bus.parity_err, bus.count); end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    send_frame(8'h1C);
    send_bits(frame(8'h1C, 1'b1, 1'b1), 11);
    tick(4);
    send_bits(frame(8'h5A, 1'b0, 1'b1), 6);
    n_checks++; if (bus.count !== 4'd1 || bus.parity_err !== 1'b1 || st !== 3'd1) begin n_fail++; $display("FAIL mid_pre: got count=%0d perr=%b state=%0d expected 1 1 1", bus.count, bus.parity_err, st); end
    clr = 1'b1;
    #1;
    n_checks++; if (bus.ready !== 1'b0 || bus.count !== 4'd0 || bus.data !== 10'h000) begin n_fail++; $display("FAIL mid_async: got ready=%b count=%0d data=%h expected 0 0 000", bus.ready, bus.count, bus.data); end
    n_checks++; if (bus.parity_err !== 1'b0 || st !== 3'd0) begin n_fail++; $display("FAIL mid_async_state: got perr=%b state=%0d expected 0 0", bus.parity_err, st); end
    tick(2);
    clr = 1'b0;
    tick(2);
    send_frame(8'h5A);
    n_checks++; if (bus.data !== 10'h05A || bus.count !== 4'd1) begin n_fail++; $display("FAIL mid_after: got %h count=%0d expected 05A 1", bus.data, bus.count); end
  endtask

  // sequence and report
  initial begin
    test_reset();
    test_valid_frame();
    test_prefix();
    test_overflow();
    test_parity();
    test_timeout();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
Parametrised PS/2 keyboard receiver that succeeds the fixed-depth keyboard block. It synchronises ps2_clk/ps2_data and deframes 11-bit PS/2 frames with parity, start, stop and timeout checking. Optionally it folds the E0 (extended) and F0 (break) prefixes into the following scan code. Decoded entries go into a show-ahead FIFO of configurable depth that feeds the 7-seg and host logic in top.

Parameters:
FIFO_DEPTH, 8, number of entries; power of 2, minimum 2
SYNC_STAGES, 3, flops on ps2_clk and ps2_data before edge detection; minimum 2
TIMEOUT_CYCLES, 20000, clk cycles allowed between ps2_clk falling edges inside a frame
DECODE_PREFIX, 1, 1 = fold E0/F0 prefixes into flags; 0 = push every byte raw

Ports:
clk  in  1  system clock, rising edge
clr  in  1  asynchronous, active-high reset
ps2_clk  in  1  raw PS/2 clock from the keyboard
ps2_data  in  1  raw PS/2 data from the keyboard
rd_en  in  1  pop the head entry; sampled on rising clk
err_clr  in  1  clears parity_err and frame_err
data  out  10  head entry {ext, brk, code[7:0]}; valid when ready=1
ready  out  1  FIFO not empty
overflow  out  1  sticky; a decoded entry was dropped because the FIFO was full
parity_err  out  1  sticky; a frame failed the odd-parity check
frame_err  out  1  sticky; bad stop bit or timeout
count  out  $clog2(FIFO_DEPTH)+1  number of entries in the FIFO

Behaviour:
- Reset (clr=1, asynchronous):
  - all outputs 0, data=10'h000;
  - FIFO pointers and count cleared, FSM to IDLE, prefix flags cleared, sync flops set to 1 (bus idle).
  - Reset takes effect immediately, including mid-frame; the partial frame is discarded.
- Sampling:
  - ps2_clk and ps2_data each pass through SYNC_STAGES flops.
  - Falling edge = previous synced ps2_clk 1, current 0.
  - Data is sampled on the clk cycle the falling edge is detected.
- FSM states:
  - IDLE: on an edge with data=0 (start bit) -> RECV, bitcnt=0, timer=0. An edge with data=1 is ignored and the FSM stays in IDLE.
  - RECV: each edge shifts the data bit into shreg, LSB first, bitcnt++. After 8 data bits -> PARITY.
  - PARITY: on the edge, latch the parity bit -> STOP.
  - STOP: on the edge:
    - if stop=1 and XOR of the 8 data bits and parity = 1 -> DELIVER;
    - if stop=1 and parity fails -> set parity_err, go to IDLE;
    - if stop=0 -> set frame_err, go to IDLE.
  - DELIVER (one cycle): apply prefix logic, push if required -> IDLE.
- Timeout: in RECV, PARITY or STOP, timer increments every clk and resets on each edge. When the timer reaches TIMEOUT_CYCLES -> set frame_err, go to IDLE, discard the shift register.
- Prefix logic:
  - DECODE_PREFIX=1:
    - code 8'hE0 sets ext_pend and is not pushed;
    - code 8'hF0 sets brk_pend and is not pushed;
    - any other code pushes {ext_pend, brk_pend, code}, then clears both flags.
  - DECODE_PREFIX=0: push {2'b00, code} for every byte.
- FIFO:
  - Circular buffer with wrap-around pointers.
  - data is combinational from the read pointer (show-ahead), so an entry is visible the cycle after its push.
  - Push latency: last ps2_clk falling edge detected -> ready=1 three clk cycles later (STOP edge, DELIVER write, visible).
  - rd_en with ready=1 pops: read pointer advances, count decrements next cycle. rd_en with ready=0 is ignored.
  - Push when count=FIFO_DEPTH and no pop that cycle: the entry is dropped, overflow=1, FIFO contents unchanged.
  - Simultaneous push and pop when full: both happen, no overflow, count unchanged.
  - Simultaneous push and pop when empty: push only.
  - overflow clears on the first accepted pop after it was set. If a new drop occurs in the same cycle as the pop, overflow stays 1.
- Error flags:
  - parity_err and frame_err hold until err_clr=1.
  - If err_clr and a new error occur in the same cycle, the new error wins and the flag stays 1.
  - Errors never block later frames.

Test Plan:
- Valid frame 0x1C, bits 0,0,0,1,1,1,0,0,0, parity 0, stop 1 -> 3 cycles after the final edge: ready=1, data=10'h01C, count=1; rd_en pulse -> ready=0, count=0.
- DECODE_PREFIX=1, frames E0, F0, 75 -> exactly one entry, data=10'h375. With DECODE_PREFIX=0, the same frames -> three entries 0E0, 0F0, 075.
- FIFO_DEPTH=8: nine frames 0x16..0x1E with no reads -> count=8, overflow=1, head 016, 0x1E lost. One pop -> overflow=0, head 017. Push and pop in the same cycle at full -> count stays 8.
- Frame 0x1C with parity bit 1 -> nothing pushed, parity_err=1. err_clr pulse -> 0. A following good frame 0x1C is accepted.
- Start bit plus 4 data bits, then ps2_clk held high for TIMEOUT_CYCLES -> frame_err=1, FSM in IDLE. A following good frame 0x29 is received correctly. A separate frame with stop bit 0 also sets frame_err.
- clr asserted after bit 5 of a frame -> outputs 0 immediately, with no clk edge needed. After release, a full new frame 0x5A -> data=10'h05A, count=1.
